// File: rtl/vga_stream_sink.sv
// Avalon-ST sink for a 30-bit RGB frame stream: repacks to 24-bit RGB, writes a
// ping-pong row buffer, queues completed rows for a consumer and resyncs on SOP.
module vga_stream_sink #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480
) (
    input  logic        clock_vga,
    input  logic        reset_n,
    input  logic [29:0] avalon_streaming_sink_data,
    input  logic        avalon_streaming_sink_startofpacket,
    input  logic        avalon_streaming_sink_endofpacket,
    input  logic        avalon_streaming_sink_valid,
    output logic        avalon_streaming_sink_ready,
    output logic [23:0] wr_data,
    output logic [10:0] wr_address,
    output logic        wr_enable,
    input  logic        row_release,
    output logic [1:0]  rows_full,
    output logic        read_bank,
    output logic [8:0]  row_index,
    output logic        frame_done,
    output logic        sync_error
);

    localparam int unsigned COL_W = 10;
    localparam int unsigned ROW_W = 9;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    typedef enum logic {
        S_WAIT_SOP = 1'b0,
        S_ACTIVE   = 1'b1
    } state_t;

    state_t             r_state;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_wr_bank;

    logic               w_ready;
    logic               w_sop;
    logic               w_eop;
    logic               w_accept;
    logic               w_take;
    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic               w_at_row_end;
    logic               w_at_last;
    logic               w_sop_err;
    logic               w_eop_abort;
    logic               w_row_end;
    logic               w_frame_end;
    logic               w_release;
    logic               w_unused_bits;

    // Ready depends only on registered state so there is no valid->ready path.
    assign w_ready = (r_state == S_WAIT_SOP) || (rows_full != 2'd2);
    assign avalon_streaming_sink_ready = w_ready;

    assign w_sop    = avalon_streaming_sink_startofpacket;
    assign w_eop    = avalon_streaming_sink_endofpacket;
    assign w_accept = avalon_streaming_sink_valid & w_ready;
    assign w_take   = w_accept & (w_sop | (r_state == S_ACTIVE));

    // An SOP beat always lands as pixel 0 of a fresh frame.
    assign w_col        = w_sop ? '0 : r_col;
    assign w_row        = w_sop ? '0 : r_row;
    assign w_at_row_end = (w_col == COL_LAST);
    assign w_at_last    = w_at_row_end && (w_row == ROW_LAST);

    assign w_sop_err   = w_accept & w_sop & (r_state == S_ACTIVE) & ((r_col != '0) | (r_row != '0));
    assign w_eop_abort = w_take & w_eop & ~w_at_last;
    assign w_row_end   = w_take & w_at_row_end & ~w_eop_abort;
    assign w_frame_end = w_take & w_at_last;
    assign w_release   = row_release & (rows_full != 2'd0);

    assign w_unused_bits = ^{avalon_streaming_sink_data[21:20],
                             avalon_streaming_sink_data[11:10],
                             avalon_streaming_sink_data[1:0]};

    always_ff @(posedge clock_vga or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_WAIT_SOP;
            r_col      <= '0;
            r_row      <= '0;
            r_wr_bank  <= 1'b0;
            rows_full  <= 2'd0;
            read_bank  <= 1'b0;
            row_index  <= '0;
            wr_enable  <= 1'b0;
            wr_data    <= '0;
            wr_address <= '0;
            frame_done <= 1'b0;
            sync_error <= 1'b0;
        end else begin
            wr_enable  <= w_take;
            frame_done <= w_frame_end & w_eop;
            sync_error <= w_sop_err | w_eop_abort | (w_frame_end & ~w_eop);

            if (w_take) begin
                wr_data    <= {avalon_streaming_sink_data[29:22],
                               avalon_streaming_sink_data[19:12],
                               avalon_streaming_sink_data[9:2]};
                wr_address <= {r_wr_bank, w_col};

                if (w_eop_abort) begin
                    // Partial row is dropped: bank and queue are left untouched.
                    r_col   <= '0;
                    r_row   <= '0;
                    r_state <= S_WAIT_SOP;
                end else if (w_at_row_end) begin
                    r_col     <= '0;
                    r_wr_bank <= ~r_wr_bank;
                    if (w_frame_end) begin
                        r_row   <= '0;
                        r_state <= S_WAIT_SOP;
                    end else begin
                        r_row   <= w_row + 9'd1;
                        r_state <= S_ACTIVE;
                    end
                end else begin
                    r_col   <= w_col + 10'd1;
                    r_row   <= w_row;
                    r_state <= S_ACTIVE;
                end
            end

            rows_full <= rows_full + 2'(w_row_end) - 2'(w_release);
            if (w_release) begin
                read_bank <= ~read_bank;
                row_index <= (row_index == ROW_LAST) ? '0 : row_index + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_stream_sink.sv
// Self-checking bench for vga_stream_sink on a reduced 8x4 frame: vector table,
// directed corner sequences and random traffic against a frame-level model.
module tb_vga_stream_sink;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [29:0] data;
    logic        sop, eop, valid, ready;
    logic [23:0] wr_data;
    logic [10:0] wr_address;
    logic        wr_enable;
    logic        row_release;
    logic [1:0]  rows_full;
    logic        read_bank;
    logic [8:0]  row_index;
    logic        frame_done, sync_error;

    int checks = 0;
    int errors = 0;

    // Model: linear pixel index within the frame plus totals of completed and released rows.
    bit          m_in_frame;
    int          m_p;
    int          m_done;
    int          m_rel;
    bit          e_we, e_fd, e_se;
    logic [10:0] e_addr;
    logic [23:0] e_data;

    vga_stream_sink #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock_vga                           (clk),
        .reset_n                             (reset_n),
        .avalon_streaming_sink_data          (data),
        .avalon_streaming_sink_startofpacket (sop),
        .avalon_streaming_sink_endofpacket   (eop),
        .avalon_streaming_sink_valid         (valid),
        .avalon_streaming_sink_ready         (ready),
        .wr_data                             (wr_data),
        .wr_address                          (wr_address),
        .wr_enable                           (wr_enable),
        .row_release                         (row_release),
        .rows_full                           (rows_full),
        .read_bank                           (read_bank),
        .row_index                           (row_index),
        .frame_done                          (frame_done),
        .sync_error                          (sync_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_p = 0; m_done = 0; m_rel = 0;
        e_we = 0; e_fd = 0; e_se = 0; e_addr = '0; e_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; valid = 0; sop = 0; eop = 0; data = '0; row_release = 0;
        model_reset();
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we", 32'(wr_enable), 32'd0);
        chk("rst_addr", 32'(wr_address), 32'd0);
        chk("rst_data", 32'(wr_data), 32'd0);
        chk("rst_rows_full", 32'(rows_full), 32'd0);
        chk("rst_read_bank", 32'(read_bank), 32'd0);
        chk("rst_row_index", 32'(row_index), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_se", 32'(sync_error), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock: drive at negedge, predict, then compare registered outputs after the edge.
    task automatic step(input bit v, input bit s, input bit e, input logic [29:0] d, input bit rl);
        bit exp_rdy, acc, rel_ok;
        int rf;
        @(negedge clk);
        valid = v; sop = s; eop = e; data = d; row_release = rl;
        #1;
        rf      = m_done - m_rel;
        exp_rdy = !m_in_frame || (rf != 2);
        chk("ready", 32'(ready), 32'(exp_rdy));
        acc    = v && exp_rdy;
        rel_ok = rl && (rf > 0);
        e_we = 0; e_fd = 0; e_se = 0;
        if (acc) begin
            if (s) begin
                if (m_in_frame && m_p != 0) e_se = 1;
                m_p = 0;
                m_in_frame = 1;
            end
            if (m_in_frame) begin
                e_we   = 1;
                e_addr = 11'((m_done % 2) * 1024 + (m_p % W));
                e_data = {d[29:22], d[19:12], d[9:2]};
                if (e && m_p != W * H - 1) begin
                    e_se = 1; m_in_frame = 0; m_p = 0;
                end else begin
                    if (m_p % W == W - 1) m_done++;
                    if (m_p == W * H - 1) begin
                        m_in_frame = 0; m_p = 0;
                        if (e) e_fd = 1; else e_se = 1;
                    end else begin
                        m_p++;
                    end
                end
            end
        end
        if (rel_ok) m_rel++;
        @(posedge clk);
        #1;
        chk("wr_enable", 32'(wr_enable), 32'(e_we));
        if (e_we) begin
            chk("wr_address", 32'(wr_address), 32'(e_addr));
            chk("wr_data", 32'(wr_data), 32'(e_data));
        end
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("sync_error", 32'(sync_error), 32'(e_se));
        chk("rows_full", 32'(rows_full), 32'(m_done - m_rel));
        chk("read_bank", 32'(read_bank), 32'(m_rel % 2));
        chk("row_index", 32'(row_index), 32'(m_rel % H));
    endtask

    typedef struct {
        bit          v, s, e, rl;
        bit          x_we;
        logic [10:0] x_addr;
        bit          x_se, x_fd;
        logic [1:0]  x_rf;
    } vec_t;

    vec_t vecs[13];
    int   n_wr, n_fd, n_se;
    bit   s_in, e_in, r_in;

    initial begin
        // junk, SOP, pixels, early EOP, junk, SOP+EOP, junk, SOP, re-SOP, pixel
        vecs[0]  = '{1, 0, 0, 0, 0, 11'd0, 0, 0, 2'd0};
        vecs[1]  = '{1, 0, 0, 0, 0, 11'd0, 0, 0, 2'd0};
        vecs[2]  = '{1, 1, 0, 0, 1, 11'd0, 0, 0, 2'd0};
        vecs[3]  = '{1, 0, 0, 0, 1, 11'd1, 0, 0, 2'd0};
        vecs[4]  = '{0, 0, 0, 0, 0, 11'd0, 0, 0, 2'd0};
        vecs[5]  = '{1, 0, 0, 0, 1, 11'd2, 0, 0, 2'd0};
        vecs[6]  = '{1, 0, 1, 0, 1, 11'd3, 1, 0, 2'd0};
        vecs[7]  = '{1, 0, 0, 0, 0, 11'd0, 0, 0, 2'd0};
        vecs[8]  = '{1, 1, 1, 0, 1, 11'd0, 1, 0, 2'd0};
        vecs[9]  = '{1, 0, 0, 1, 0, 11'd0, 0, 0, 2'd0};
        vecs[10] = '{1, 1, 0, 0, 1, 11'd0, 0, 0, 2'd0};
        vecs[11] = '{1, 1, 0, 0, 1, 11'd0, 1, 0, 2'd0};
        vecs[12] = '{1, 0, 0, 0, 1, 11'd1, 0, 0, 2'd0};

        reset_n = 1'b0; valid = 0; sop = 0; eop = 0; data = '0; row_release = 0;
        model_reset();
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].s, vecs[i].e, 30'($urandom), vecs[i].rl);
            chk("tbl_we", 32'(wr_enable), 32'(vecs[i].x_we));
            if (vecs[i].x_we) chk("tbl_addr", 32'(wr_address), 32'(vecs[i].x_addr));
            chk("tbl_se", 32'(sync_error), 32'(vecs[i].x_se));
            chk("tbl_fd", 32'(frame_done), 32'(vecs[i].x_fd));
            chk("tbl_rf", 32'(rows_full), 32'(vecs[i].x_rf));
        end

        // Release on the same cycle a row completes while one row is queued.
        do_reset();
        for (int i = 0; i < 2 * W - 1; i++) step(1, i == 0, 0, 30'($urandom), 0);
        chk("pre_same_rf", 32'(rows_full), 32'd1);
        step(1, 0, 0, 30'($urandom), 1);
        chk("same_rf", 32'(rows_full), 32'd1);
        chk("same_rb", 32'(read_bank), 32'd1);
        chk("same_ri", 32'(row_index), 32'd1);

        // SOP injected at row 2, col 5.
        step(0, 0, 0, '0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 30'($urandom), 0);
        step(1, 1, 0, 30'($urandom), 0);
        chk("inj_se", 32'(sync_error), 32'd1);
        chk("inj_addr", 32'(wr_address), 32'd0);
        chk("inj_rf", 32'(rows_full), 32'd0);

        // Early EOP, then non-SOP beats must be dropped.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 30'($urandom), 0);
        step(1, 0, 1, 30'($urandom), 0);
        chk("eop_se", 32'(sync_error), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 30'($urandom), 0);
            chk("eop_drop_we", 32'(wr_enable), 32'd0);
        end

        // Back-pressure with both banks full, then a single release.
        do_reset();
        n_wr = 0;
        for (int i = 0; i < 3 * W; i++) begin
            step(1, i == 0, 0, 30'($urandom), 0);
            if (wr_enable) n_wr++;
        end
        chk("stall_writes", 32'(n_wr), 32'(2 * W));
        chk("stall_ready", 32'(ready), 32'd0);
        chk("stall_rf", 32'(rows_full), 32'd2);
        step(1, 0, 0, 30'($urandom), 1);
        chk("stall_rel_we", 32'(wr_enable), 32'd0);
        chk("resume_ready", 32'(ready), 32'd1);
        step(1, 0, 0, 30'($urandom), 0);
        chk("resume_we", 32'(wr_enable), 32'd1);
        chk("resume_addr", 32'(wr_address), 32'd0);

        // Reset lands mid-row; do_reset checks outputs return to reset values.
        do_reset();

        // Clean frame with releases as soon as rows are queued.
        n_wr = 0; n_fd = 0; n_se = 0;
        for (int i = 0; i < 4 * W * H && !(n_wr == W * H); i++) begin
            s_in = !m_in_frame;
            e_in = m_in_frame && (m_p == W * H - 1);
            step(1, s_in, e_in, 30'($urandom), (m_done - m_rel) > 0);
            if (wr_enable) n_wr++;
            if (frame_done) n_fd++;
            if (sync_error) n_se++;
        end
        chk("clean_writes", 32'(n_wr), 32'(W * H));
        chk("clean_frame_done", 32'(n_fd), 32'd1);
        chk("clean_sync_error", 32'(n_se), 32'd0);

        // Random traffic with occasional framing faults.
        for (int i = 0; i < 3000; i++) begin
            s_in = m_in_frame ? ($urandom % 64 == 0) : ($urandom % 4 == 0);
            e_in = (m_in_frame && m_p == W * H - 1) ? ($urandom % 8 != 0) : ($urandom % 128 == 0);
            r_in = ($urandom % 10) < 3;
            step(($urandom % 5) != 0, s_in, e_in, 30'($urandom), r_in);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
